// File: rtl/arena_access_arbiter.sv
// arena_access_arbiter
//   Serialises the two players' move/bomb requests onto the shared single-port
//   arena map (100 x 2b) and bomb map (100 x 1b). It arbitrates round-robin,
//   then runs read-check-write on the maps. Each player's position is tracked here.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     pN_req / pN_op           request (held until ack), op 0=up 1=down 2=left 3=right 4=bomb
//     pN_ack / pN_ok           one-cycle completion pulse, ok=1 when applied
//     pN_row / pN_col          current position of player N
//     mem_addr                 row*10+col, shared by both maps
//     arena_rdata, bomb_rdata  map read data, valid one cycle after mem_addr
//     arena_we / arena_wdata   arena write port
//     bomb_we                  bomb write strobe (data is implicitly 1)
//
//   Build option: define MOVE_STATS_EN to add p1_moves/p2_moves, which are
//   saturating 8-bit counters of applied moves.
module arena_access_arbiter #(
    parameter int P1_ROW0 = 0,
    parameter int P1_COL0 = 0,
    parameter int P2_ROW0 = 9,
    parameter int P2_COL0 = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p1_req,
    input  logic [2:0] p1_op,
    output logic       p1_ack,
    output logic       p1_ok,
    output logic [3:0] p1_row,
    output logic [3:0] p1_col,
    input  logic       p2_req,
    input  logic [2:0] p2_op,
    output logic       p2_ack,
    output logic       p2_ok,
    output logic [3:0] p2_row,
    output logic [3:0] p2_col,
    output logic [6:0] mem_addr,
    input  logic [1:0] arena_rdata,
    input  logic       bomb_rdata,
    output logic       arena_we,
    output logic [1:0] arena_wdata,
    output logic       bomb_we
`ifdef MOVE_STATS_EN
    ,
    output logic [7:0] p1_moves,
    output logic [7:0] p2_moves
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CALC    = 3'd1;
    localparam logic [2:0] S_RD      = 3'd2;
    localparam logic [2:0] S_CHK     = 3'd3;
    localparam logic [2:0] S_WR_DST  = 3'd4;
    localparam logic [2:0] S_WR_SRC  = 3'd5;
    localparam logic [2:0] S_WR_BOMB = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam logic [3:0] P1_R0 = 4'(P1_ROW0);
    localparam logic [3:0] P1_C0 = 4'(P1_COL0);
    localparam logic [3:0] P2_R0 = 4'(P2_ROW0);
    localparam logic [3:0] P2_C0 = 4'(P2_COL0);

    function automatic logic [6:0] cell_addr(input logic [3:0] r, input logic [3:0] c);
        return 7'(r) * 7'd10 + 7'(c);
    endfunction

    logic [2:0] state_q, state_d;
    logic       gnt_q, gnt_d;        // 0 = P1, 1 = P2
    logic       prio_q, prio_d;      // player preferred on a tie
    logic [2:0] op_q, op_d;
    logic [3:0] dst_row_q, dst_row_d, dst_col_q, dst_col_d;
    logic       ok_q, ok_d;
    logic       hold_q, hold_d;      // denial settle cycle before ack
    logic [6:0] mem_addr_q, mem_addr_d;
    logic [3:0] p1_row_q, p1_row_d, p1_col_q, p1_col_d;
    logic [3:0] p2_row_q, p2_row_d, p2_col_q, p2_col_d;
`ifdef MOVE_STATS_EN
    logic [7:0] p1_moves_q, p1_moves_d, p2_moves_q, p2_moves_d;
`endif

    logic [3:0] cur_row, cur_col, nxt_row, nxt_col;
    logic       in_range;
    logic       ack_any;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        prio_d     = prio_q;
        op_d       = op_q;
        dst_row_d  = dst_row_q;
        dst_col_d  = dst_col_q;
        ok_d       = ok_q;
        hold_d     = hold_q;
        mem_addr_d = mem_addr_q;
        p1_row_d   = p1_row_q;
        p1_col_d   = p1_col_q;
        p2_row_d   = p2_row_q;
        p2_col_d   = p2_col_q;
`ifdef MOVE_STATS_EN
        p1_moves_d = p1_moves_q;
        p2_moves_d = p2_moves_q;
`endif
        cur_row  = gnt_q ? p2_row_q : p1_row_q;
        cur_col  = gnt_q ? p2_col_q : p1_col_q;
        nxt_row  = cur_row;
        nxt_col  = cur_col;
        in_range = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (p1_req || p2_req) begin
                    gnt_d   = (p1_req && p2_req) ? prio_q : p2_req;
                    prio_d  = ~gnt_d;
                    op_d    = gnt_d ? p2_op : p1_op;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                case (op_q)
                    3'd0: begin in_range = (cur_row != 4'd0); nxt_row = cur_row - 4'd1; end
                    3'd1: begin in_range = (cur_row != 4'd9); nxt_row = cur_row + 4'd1; end
                    3'd2: begin in_range = (cur_col != 4'd0); nxt_col = cur_col - 4'd1; end
                    3'd3: begin in_range = (cur_col != 4'd9); nxt_col = cur_col + 4'd1; end
                    3'd4: in_range = 1'b1;  // bomb targets own cell
                    default: in_range = 1'b0;
                endcase
                if (in_range) begin
                    dst_row_d  = nxt_row;
                    dst_col_d  = nxt_col;
                    mem_addr_d = cell_addr(nxt_row, nxt_col);
                    state_d    = S_RD;
                end else begin
                    ok_d    = 1'b0;
                    hold_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RD: state_d = S_CHK;  // address is out; data lands next cycle
            S_CHK: begin
                if (op_q == 3'd4 ? !bomb_rdata : (arena_rdata == 2'd0 && !bomb_rdata)) begin
                    state_d = (op_q == 3'd4) ? S_WR_BOMB : S_WR_DST;
                end else begin
                    ok_d    = 1'b0;
                    hold_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WR_DST: begin
                // Switch the address at the edge so it is stable for the whole WR_SRC cycle.
                mem_addr_d = cell_addr(cur_row, cur_col);
                state_d    = S_WR_SRC;
            end
            S_WR_SRC: begin
                if (gnt_q) begin
                    p2_row_d = dst_row_q;
                    p2_col_d = dst_col_q;
`ifdef MOVE_STATS_EN
                    if (p2_moves_q != 8'hFF) p2_moves_d = p2_moves_q + 8'd1;
`endif
                end else begin
                    p1_row_d = dst_row_q;
                    p1_col_d = dst_col_q;
`ifdef MOVE_STATS_EN
                    if (p1_moves_q != 8'hFF) p1_moves_d = p1_moves_q + 8'd1;
`endif
                end
                ok_d    = 1'b1;
                hold_d  = 1'b0;
                state_d = S_DONE;
            end
            S_WR_BOMB: begin
                ok_d    = 1'b1;
                hold_d  = 1'b0;
                state_d = S_DONE;
            end
            default: begin  // S_DONE
                // Denials linger one cycle here so they ack at +2 (range) / +4 (CHK).
                if (hold_q) hold_d = 1'b0;
                else        state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= 1'b0;
            prio_q     <= 1'b0;
            op_q       <= 3'd0;
            dst_row_q  <= 4'd0;
            dst_col_q  <= 4'd0;
            ok_q       <= 1'b0;
            hold_q     <= 1'b0;
            mem_addr_q <= 7'd0;
            p1_row_q   <= P1_R0;
            p1_col_q   <= P1_C0;
            p2_row_q   <= P2_R0;
            p2_col_q   <= P2_C0;
`ifdef MOVE_STATS_EN
            p1_moves_q <= 8'd0;
            p2_moves_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            prio_q     <= prio_d;
            op_q       <= op_d;
            dst_row_q  <= dst_row_d;
            dst_col_q  <= dst_col_d;
            ok_q       <= ok_d;
            hold_q     <= hold_d;
            mem_addr_q <= mem_addr_d;
            p1_row_q   <= p1_row_d;
            p1_col_q   <= p1_col_d;
            p2_row_q   <= p2_row_d;
            p2_col_q   <= p2_col_d;
`ifdef MOVE_STATS_EN
            p1_moves_q <= p1_moves_d;
            p2_moves_q <= p2_moves_d;
`endif
        end
    end

    assign ack_any     = (state_q == S_DONE) && !hold_q;
    assign p1_ack      = ack_any && !gnt_q;
    assign p2_ack      = ack_any && gnt_q;
    assign p1_ok       = p1_ack && ok_q;
    assign p2_ok       = p2_ack && ok_q;
    assign p1_row      = p1_row_q;
    assign p1_col      = p1_col_q;
    assign p2_row      = p2_row_q;
    assign p2_col      = p2_col_q;
    assign mem_addr    = mem_addr_q;
    assign arena_we    = (state_q == S_WR_DST) || (state_q == S_WR_SRC);
    assign arena_wdata = (state_q == S_WR_DST) ? (gnt_q ? 2'd3 : 2'd2) : 2'd0;
    assign bomb_we     = (state_q == S_WR_BOMB);
`ifdef MOVE_STATS_EN
    assign p1_moves    = p1_moves_q;
    assign p2_moves    = p2_moves_q;
`endif

endmodule

// File: tb/tb_arena_access_arbiter.sv
// Bench for arena_access_arbiter: environment RAMs, a transaction-level model
// of the maps/positions, and a scoreboard checked by a forked ack monitor.
module tb_arena_access_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       p1_req, p2_req;
    logic [2:0] p1_op, p2_op;
    logic       p1_ack, p1_ok, p2_ack, p2_ok;
    logic [3:0] p1_row, p1_col, p2_row, p2_col;
    logic [6:0] mem_addr;
    logic [1:0] arena_rdata;
    logic       bomb_rdata;
    logic       arena_we;
    logic [1:0] arena_wdata;
    logic       bomb_we;
`ifdef MOVE_STATS_EN
    logic [7:0] p1_moves, p2_moves;
`endif

    always #5 clk = ~clk;

    arena_access_arbiter dut (
        .clk(clk), .rst(rst),
        .p1_req(p1_req), .p1_op(p1_op), .p1_ack(p1_ack), .p1_ok(p1_ok), .p1_row(p1_row), .p1_col(p1_col),
        .p2_req(p2_req), .p2_op(p2_op), .p2_ack(p2_ack), .p2_ok(p2_ok), .p2_row(p2_row), .p2_col(p2_col),
        .mem_addr(mem_addr), .arena_rdata(arena_rdata), .bomb_rdata(bomb_rdata),
        .arena_we(arena_we), .arena_wdata(arena_wdata), .bomb_we(bomb_we)
`ifdef MOVE_STATS_EN
        , .p1_moves(p1_moves), .p2_moves(p2_moves)
`endif
    );

    // ---------------- environment RAMs (registered read) ----------------
    logic [1:0] ram_a [100];
    logic       ram_b [100];
    logic [1:0] init_a [100];
    logic       init_b [100];
    logic       load = 1'b0;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) begin
            for (int i = 0; i < 100; i++) begin
                ram_a[i] <= init_a[i];
                ram_b[i] <= init_b[i];
            end
        end else if (mem_addr < 7'd100) begin
            arena_rdata <= ram_a[mem_addr];
            bomb_rdata  <= ram_b[mem_addr];
            if (arena_we) ram_a[mem_addr] <= arena_wdata;
            if (bomb_we)  ram_b[mem_addr] <= 1'b1;
        end
    end

    // ---------------- reference model ----------------
    int m_a [100];
    int m_b [100];
    int mrow [2];
    int mcol [2];
    int mmoves [2];
    int last;            // player served last (0 = P1, 1 = P2)

    typedef struct { int pl; int ok; int row; int col; int cyc; } exp_t;
    exp_t sbq [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One transaction against the model maps; returns outcome and ack latency.
    task automatic model_txn(input int p, input int op, output int ok, output int lat);
        int r, c, nr, nc, src, dst;
        r = mrow[p]; c = mcol[p]; nr = r; nc = c; ok = 0; lat = 2;
        if (op > 4) return;
        case (op)
            0: nr = r - 1;
            1: nr = r + 1;
            2: nc = c - 1;
            3: nc = c + 1;
            default: ;
        endcase
        if (nr < 0 || nr > 9 || nc < 0 || nc > 9) return;
        lat = 4;
        src = r * 10 + c;
        dst = nr * 10 + nc;
        if (op == 4) begin
            if (m_b[src] == 0) begin m_b[src] = 1; ok = 1; end
            return;
        end
        if (m_a[dst] != 0 || m_b[dst] != 0) return;
        m_a[dst] = p + 2;
        m_a[src] = 0;
        mrow[p] = nr; mcol[p] = nc;
        if (mmoves[p] < 255) mmoves[p]++;
        ok = 1; lat = 5;
    endtask

    task automatic monitor();
        exp_t e;
        int pl, aok, arow, acol;
        forever begin
            @(negedge clk);
            if (arena_we || bomb_we) chk("we_onehot", int'(arena_we && bomb_we), 0);
            if (p1_ack || p2_ack) begin
                checks++;
                pl   = p2_ack ? 1 : 0;
                aok  = pl ? int'(p2_ok) : int'(p1_ok);
                arow = pl ? int'(p2_row) : int'(p1_row);
                acol = pl ? int'(p2_col) : int'(p1_col);
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: player %0d acked at cycle %0d, none expected", pl + 1, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (p1_ack && p2_ack || pl != e.pl || aok != e.ok || arow != e.row || acol != e.col || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL ack: got pl=%0d ok=%0d pos=(%0d,%0d) cyc=%0d, expected pl=%0d ok=%0d pos=(%0d,%0d) cyc=%0d",
                                 pl + 1, aok, arow, acol, cyc, e.pl + 1, e.ok, e.row, e.col, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic check_state(input string nm);
        int diffs;
        diffs = 0;
        for (int i = 0; i < 100; i++)
            if (int'(ram_a[i]) != m_a[i] || int'(ram_b[i]) != m_b[i]) diffs++;
        chk({nm, "_map_diffs"}, diffs, 0);
        chk({nm, "_pos"}, {int'(p1_row), int'(p1_col), int'(p2_row), int'(p2_col)} == {mrow[0], mcol[0], mrow[1], mcol[1]} ? 1 : 0, 1);
`ifdef MOVE_STATS_EN
        chk({nm, "_moves1"}, int'(p1_moves), mmoves[0]);
        chk({nm, "_moves2"}, int'(p2_moves), mmoves[1]);
`endif
    endtask

    // A round: one or both players request together; hold each until its ack.
    task automatic round(input int r1, input int r2, input int op1, input int op2, input int early);
        int k, first, second, ok, l1, l2, acks, want, t;
        @(negedge clk);
        k = cyc;  // IDLE samples the request at edge k+1
        first = (r1 != 0 && r2 != 0) ? ((last == 0) ? 1 : 0) : ((r1 != 0) ? 0 : 1);
        model_txn(first, first ? op2 : op1, ok, l1);
        sbq.push_back('{first, ok, mrow[first], mcol[first], k + 1 + l1});
        last = first; want = 1;
        if (r1 != 0 && r2 != 0) begin
            second = 1 - first;
            model_txn(second, second ? op2 : op1, ok, l2);
            sbq.push_back('{second, ok, mrow[second], mcol[second], k + 1 + l1 + 2 + l2});
            last = second; want = 2;
        end
        p1_req = (r1 != 0); p1_op = 3'(op1);
        p2_req = (r2 != 0); p2_op = 3'(op2);
        acks = 0; t = 0;
        while (acks < want && t < 60) begin
            @(negedge clk);
            t++;
            if (early != 0 && cyc == k + 1) begin p1_req = 1'b0; p2_req = 1'b0; end
            if (p1_ack) begin p1_req = 1'b0; acks++; end
            if (p2_ack) begin p2_req = 1'b0; acks++; end
        end
        if (acks < want) begin
            checks++; errors++;
            $display("FAIL round_timeout: got %0d acks, expected %0d", acks, want);
            sbq.delete();
        end
        p1_req = 1'b0; p2_req = 1'b0;
        check_state("round");
    endtask

    task automatic init_maps(input int wall_pct, input int fixed_walls);
        int walls [8] = '{22, 33, 51, 62, 73, 84, 57, 68};
        for (int i = 0; i < 100; i++) begin
            m_a[i] = (i != 0 && i != 99 && $urandom_range(0, 99) < wall_pct) ? 1 : 0;
            m_b[i] = 0;
        end
        if (fixed_walls != 0) foreach (walls[j]) m_a[walls[j]] = 1;
        m_a[0] = 2; m_a[99] = 3;
        for (int i = 0; i < 100; i++) begin
            init_a[i] = 2'(m_a[i]);
            init_b[i] = 1'b0;
        end
        mrow[0] = 0; mcol[0] = 0; mrow[1] = 9; mcol[1] = 9;
        mmoves[0] = 0; mmoves[1] = 0; last = 1;
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    initial begin
        int t, sel, r1, r2, o1, o2;
        rst = 1'b1; p1_req = 1'b0; p2_req = 1'b0; p1_op = 3'd0; p2_op = 3'd0;
        fork monitor(); join_none
        init_maps(0, 1);
        #1;
        chk("rst_ack", int'({p1_ack, p2_ack, p1_ok, p2_ok}), 0);
        chk("rst_we", int'({arena_we, bomb_we}), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_pos", int'({p1_row, p1_col, p2_row, p2_col}), 16'h0099);
        @(negedge clk); rst = 1'b0;

        // both at once after reset: P1 first, then P2; next pair follows the rr pointer
        round(1, 1, 3, 2, 0);
        round(1, 1, 2, 3, 0);
        round(1, 0, 0, 0, 0);          // up from row 0: range deny, +2
        round(1, 0, 1, 0, 0);          // down into empty cell 10, +5
        round(1, 0, 4, 0, 0);          // bomb at own cell
        round(1, 0, 4, 0, 0);          // second bomb denied
        for (int i = 0; i < 4; i++) round(1, 0, 3, 0, 0);
        for (int i = 0; i < 3; i++) round(1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) round(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) round(0, 1, 0, 2, 0);
        chk("pre45_pos", int'({p1_row, p1_col, p2_row, p2_col}), 16'h4446);
        round(1, 1, 3, 2, 0);          // both into cell 45
        chk("cell45_owner", int'(ram_a[45]), 2);
        round(1, 0, 7, 0, 1);          // op 7 denied, req dropped early

        // reset in the middle of WR_DST
        @(negedge clk); p1_req = 1'b1; p1_op = 3'd1;
        t = 0;
        while (!(arena_we && arena_wdata == 2'd2) && t < 20) begin @(negedge clk); t++; end
        chk("rst_mid_reach_wr_dst", int'(t < 20), 1);
        rst = 1'b1; p1_req = 1'b0;
        #1;
        chk("rst_mid_we", int'({arena_we, bomb_we}), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_quiet", int'({arena_we, bomb_we, p1_ack, p2_ack}), 0);
        end
        chk("rst_mid_pos", int'({p1_row, p1_col, p2_row, p2_col}), 16'h0099);
        chk("rst_mid_ram55", int'(ram_a[55]), 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_idle", int'({arena_we, bomb_we, p1_ack, p2_ack}), 0);
        end

        // randomized phase on a fresh board
        rst = 1'b1;
        init_maps(12, 0);
        @(negedge clk); rst = 1'b0;
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(1, 3);
            r1 = (sel != 2) ? 1 : 0;
            r2 = (sel != 1) ? 1 : 0;
            o1 = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 4) : $urandom_range(5, 7);
            o2 = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 4) : $urandom_range(5, 7);
            round(r1, r2, o1, o2, (r1 + r2 == 1 && $urandom_range(0, 3) == 0) ? 1 : 0);
        end
        chk("sb_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
